alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Downstream stage of the 32-bit ALU.
- Registers the ALU's result, carryout, zero and overflow outputs, plus the 3-bit command that produced them, into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Keeps a saturating count of arithmetic overflows so that writeback or trace logic can apply backpressure without losing ALU outputs.

Parameters:
- WIDTH, 32, datapath width; matches the ALU operand and result width.
- CNT_WIDTH, 16, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU outputs on in_* are valid this cycle.
- in_ready  output  1  buffer can accept this cycle; registered, depends only on state.
- in_result  input  WIDTH  ALU result.
- in_carryout  input  1  ALU carryout.
- in_zero  input  1  ALU zero flag.
- in_overflow  input  1  ALU overflow flag.
- in_command  input  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- out_valid  output  1  out_* holds a valid entry.
- out_ready  input  1  consumer accepts this cycle.
- out_result  output  WIDTH  buffered result.
- out_carryout  output  1  buffered carryout.
- out_zero  output  1  buffered zero flag.
- out_overflow  output  1  buffered overflow flag.
- out_command  output  3  buffered command.
- ovf_count  output  CNT_WIDTH  saturating count of accepted arithmetic overflows.
- clear_stat  input  1  synchronous clear of ovf_count and the sticky flags.
- sticky_ovf  output  1  see Optional Feature.
- sticky_carry  output  1  see Optional Feature.

Behaviour:
- Handshakes:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (pop) = out_valid & out_ready.
- Storage:
  - Main register (drives out_*) and one skid register.
  - State EMPTY / ONE / FULL, encoded 2 bits.
- Reset (async, rst_n=0):
  - state=EMPTY, in_ready=1, out_valid=0.
  - out_result=0, all out_* flags=0, out_command=0.
  - ovf_count=0, sticky flags=0.
- Transitions:
  - EMPTY, acc: load main -> ONE.
  - ONE, acc & !pop: load skid -> FULL.
  - ONE, acc & pop: load main with input, stay ONE.
  - ONE, !acc & pop: -> EMPTY.
  - FULL, pop: skid -> main -> ONE. No accept possible in FULL.
- in_ready = (state != FULL), registered.
- out_valid = (state != EMPTY).
- Latency: 1 cycle, in to out, when EMPTY.
- Throughput: 1 per cycle while out_ready=1.
- Ordering: strict FIFO; no entry dropped or duplicated.
- in_* are ignored when acc=0. out_* are held stable while out_valid & !out_ready.
- ovf_count:
  - Increments on acc when in_overflow=1 and in_command is ADD or SUB.
  - Overflow on other commands is not counted.
  - Saturates at all-ones.
- clear_stat:
  - Zeroes ovf_count next cycle.
  - If clear_stat and a counted event occur in the same cycle, clear wins: result 0.
  - Buffer contents are unaffected.
- Reset asserted mid-transfer discards both entries immediately. No output is valid until the first acc after rst_n deasserts.

Optional Feature:
- Macro: ALU_RESULT_STICKY_EN.
- Defined:
  - sticky_ovf sets on any counted overflow event.
  - sticky_carry sets on acc with in_carryout=1 and command ADD or SUB.
  - Both hold until clear_stat or reset; clear wins over a same-cycle set.
- Undefined: sticky_ovf and sticky_carry are tied to 0 and no flops are instantiated.

Decomposition:
- Shared package/include holds:
  - ALU command constants ADD..OR, 3 bits.
  - State encodings EMPTY=0, ONE=1, FULL=2.
  - Entry width constant WIDTH+3+3 (result + 3 flags + command).
- One natural sub-module: alu_skid_reg.
  - Generic payload-width 2-entry skid register with handshake.
  - Instantiated once with the packed entry.
  - Counter and sticky logic stay in the parent.

Test Plan:
- Reset then single ADD: acc of result=0x0000_0005, zero=0, out_ready=1 -> out_valid=1 one cycle later, out_result=0x5, then out_valid=0 the next cycle.
- Backpressure with out_ready=0 and three back-to-back acc attempts (0x1, 0x2, 0x3):
  - First two accepted; in_ready=0 from cycle 2 onward; third held off.
  - Releasing out_ready yields 0x1, 0x2, 0x3 in order with no gaps.
- Full streaming, in_valid=out_ready=1 for 100 cycles with an incrementing result -> in_ready stays 1 and outputs match inputs delayed by 1 cycle.
- Overflow counting:
  - 5 accepted SUBs with overflow=1 and 3 accepted XORs with overflow=1 -> ovf_count=5.
  - With CNT_WIDTH=2, the same 5 SUBs -> ovf_count saturates at 3.
- clear_stat asserted in the same cycle as a counted ADD overflow -> ovf_count=0 next cycle; with ALU_RESULT_STICKY_EN, sticky_ovf=0.
- rst_n pulsed low while FULL -> out_valid=0 and in_ready=1 immediately; the next accepted 0xA5A5_A5A5 appears alone at the output.

Source files
------------

// File: rtl/alu_result_buffer_pkg.sv
// Shared types for the ALU result buffer: command codes, buffer state and entry sizing.
package alu_result_buffer_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int FLAG_BITS = 3;
  localparam int CMD_BITS  = 3;

  // Packed entry is {result, carryout, zero, overflow, command}.
  function automatic int entry_width(input int width);
    return width + FLAG_BITS + CMD_BITS;
  endfunction

  function automatic logic is_arith(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// ALU-side and consumer-side streams of the result buffer; master is the producer/consumer
// environment, slave is the buffer. A transfer happens on a side when valid & ready are both high.
interface alu_result_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carryout;
  logic             in_zero;
  logic             in_overflow;
  logic [2:0]       in_command;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carryout;
  logic             out_zero;
  logic             out_overflow;
  logic [2:0]       out_command;

  modport master (
    output in_valid, in_result, in_carryout, in_zero, in_overflow, in_command, out_ready,
    input  in_ready, out_valid, out_result, out_carryout, out_zero, out_overflow, out_command
  );

  modport slave (
    input  in_valid, in_result, in_carryout, in_zero, in_overflow, in_command, out_ready,
    output in_ready, out_valid, out_result, out_carryout, out_zero, out_overflow, out_command
  );
endinterface

// File: rtl/alu_skid_reg.sv
// Generic 2-entry skid register: main register drives the output, skid catches one extra
// entry so in_ready can be registered without losing data.
module alu_skid_reg
  import alu_result_buffer_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_e   dbg_state
);

  buf_state_e   r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         w_acc;
  logic         w_pop;

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main      <= in_data;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_pop) begin
            r_skid     <= in_data;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (w_acc && w_pop) begin
            r_main <= in_data;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (w_pop) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign dbg_state = r_state;

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU outputs in a 2-entry skid register and counts accepted ADD/SUB overflows.
// Optional sticky overflow/carry flags are built when ALU_RESULT_STICKY_EN is defined.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_buffer_if.slave   bus,
  input  logic                 clear_stat,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic                 sticky_ovf,
  output logic                 sticky_carry,
  output buf_state_e           dbg_state
);

  localparam int ENTRY_W = entry_width(WIDTH);

  logic [ENTRY_W-1:0]   w_in_entry;
  logic [ENTRY_W-1:0]   w_out_entry;
  logic                 w_acc;
  logic                 w_ovf_evt;
  logic [CNT_WIDTH-1:0] r_ovf_count;

  assign w_in_entry = {bus.in_result, bus.in_carryout, bus.in_zero, bus.in_overflow, bus.in_command};

  alu_skid_reg #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (w_in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_out_entry),
    .dbg_state (dbg_state)
  );

  assign {bus.out_result, bus.out_carryout, bus.out_zero, bus.out_overflow, bus.out_command} = w_out_entry;

  assign w_acc     = bus.in_valid & bus.in_ready;
  assign w_ovf_evt = w_acc & bus.in_overflow & is_arith(bus.in_command);

  // Clear has priority over a same-cycle event; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (clear_stat) begin
      r_ovf_count <= '0;
    end else if (w_ovf_evt && (r_ovf_count != {CNT_WIDTH{1'b1}})) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign ovf_count = r_ovf_count;

`ifdef ALU_RESULT_STICKY_EN
  logic w_carry_evt;
  logic r_sticky_ovf;
  logic r_sticky_carry;

  assign w_carry_evt = w_acc & bus.in_carryout & is_arith(bus.in_command);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf   <= 1'b0;
      r_sticky_carry <= 1'b0;
    end else if (clear_stat) begin
      r_sticky_ovf   <= 1'b0;
      r_sticky_carry <= 1'b0;
    end else begin
      if (w_ovf_evt)   r_sticky_ovf   <= 1'b1;
      if (w_carry_evt) r_sticky_carry <= 1'b1;
    end
  end

  assign sticky_ovf   = r_sticky_ovf;
  assign sticky_carry = r_sticky_carry;
`else
  assign sticky_ovf   = 1'b0;
  assign sticky_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: handshake, ordering, overflow counting, clear and reset.
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

`ifdef ALU_RESULT_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear_stat;
  logic [15:0] ovf_count;
  logic [1:0]  ovf_count2;
  logic        sticky_ovf, sticky_carry, sticky_ovf2, sticky_carry2;
  logic [1:0]  dbg_state, dbg_state2;

  int n_checks = 0;
  int n_pass   = 0;

  alu_result_buffer_if #(.WIDTH(32)) u_if  ();
  alu_result_buffer_if #(.WIDTH(32)) u_if2 ();

  alu_result_buffer #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if), .clear_stat(clear_stat), .ovf_count(ovf_count),
    .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry), .dbg_state(dbg_state)
  );

  alu_result_buffer #(.WIDTH(32), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(u_if2), .clear_stat(clear_stat), .ovf_count(ovf_count2),
    .sticky_ovf(sticky_ovf2), .sticky_carry(sticky_carry2), .dbg_state(dbg_state2)
  );

  // Second instance sees exactly the same stimulus.
  assign u_if2.in_valid    = u_if.in_valid;
  assign u_if2.in_result   = u_if.in_result;
  assign u_if2.in_carryout = u_if.in_carryout;
  assign u_if2.in_zero     = u_if.in_zero;
  assign u_if2.in_overflow = u_if.in_overflow;
  assign u_if2.in_command  = u_if.in_command;
  assign u_if2.out_ready   = u_if.out_ready;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic cf, input logic ov,
                       input logic [2:0] cmd);
    u_if.in_valid    = v;
    u_if.in_result   = res;
    u_if.in_carryout = cf;
    u_if.in_zero     = (res == 32'd0);
    u_if.in_overflow = ov;
    u_if.in_command  = cmd;
  endtask

  initial begin
    rst_n        = 1'b0;
    clear_stat   = 1'b0;
    u_if.out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, CMD_ADD);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // reset state
    check("rst_in_ready",  u_if.in_ready,  1'b1);
    check("rst_out_valid", u_if.out_valid, 1'b0);
    check("rst_out_result", u_if.out_result, 32'd0);
    check("rst_out_flags", {u_if.out_carryout, u_if.out_zero, u_if.out_overflow, u_if.out_command}, 6'd0);
    check("rst_ovf_count", ovf_count, 16'd0);
    check("rst_sticky", {sticky_ovf, sticky_carry}, 2'b00);

    // single ADD, 1-cycle latency
    u_if.out_ready = 1'b1;
    drive(1'b1, 32'h5, 1'b0, 1'b0, CMD_ADD);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    check("single_valid", u_if.out_valid, 1'b1);
    check("single_result", u_if.out_result, 32'h5);
    check("single_zero", u_if.out_zero, 1'b0);
    step();
    check("single_drain", u_if.out_valid, 1'b0);

    // backpressure: two accepted, third held off
    u_if.out_ready = 1'b0;
    drive(1'b1, 32'h1, 1'b0, 1'b0, CMD_AND);
    step();
    check("bp_ready_c1", u_if.in_ready, 1'b1);
    drive(1'b1, 32'h2, 1'b0, 1'b0, CMD_OR);
    step();
    check("bp_ready_c2", u_if.in_ready, 1'b0);
    drive(1'b1, 32'h3, 1'b0, 1'b0, CMD_XOR);
    step();
    check("bp_ready_c3", u_if.in_ready, 1'b0);
    check("bp_hold_result", u_if.out_result, 32'h1);
    check("bp_hold_cmd", u_if.out_command, CMD_AND);
    step();
    check("bp_hold2_result", u_if.out_result, 32'h1);
    check("bp_state_full", dbg_state, ST_FULL);
    u_if.out_ready = 1'b1;
    step();
    check("bp_out2_valid", u_if.out_valid, 1'b1);
    check("bp_out2_result", u_if.out_result, 32'h2);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    check("bp_out3_valid", u_if.out_valid, 1'b1);
    check("bp_out3_result", u_if.out_result, 32'h3);
    check("bp_out3_cmd", u_if.out_command, CMD_XOR);
    step();
    check("bp_drain", u_if.out_valid, 1'b0);

    // full-rate streaming
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h100 + i, 1'b0, 1'b0, CMD_SLT);
      step();
      check("stream_ready", u_if.in_ready, 1'b1);
      check("stream_result", {u_if.out_valid, u_if.out_result}, {1'b1, 32'h100 + i});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    step();
    check("stream_drain", u_if.out_valid, 1'b0);
    check("stream_no_ovf", ovf_count, 16'd0);

    // overflow counting: 5 SUB counted, 3 XOR not
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h8000_0000 + i, 1'b0, 1'b1, CMD_SUB);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h7 + i, 1'b0, 1'b1, CMD_XOR);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    step();
    check("ovf_count5", ovf_count, 16'd5);
    check("ovf_sat", ovf_count2, 2'd3);
    check("ovf_sticky", sticky_ovf, STICKY);
    check("ovf_sticky_carry", sticky_carry, 1'b0);

    // clear wins over a same-cycle counted ADD overflow (with carry)
    clear_stat = 1'b1;
    drive(1'b1, 32'h1234, 1'b1, 1'b1, CMD_ADD);
    step();
    clear_stat = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    check("clr_count", ovf_count, 16'd0);
    check("clr_count_sat", ovf_count2, 2'd0);
    check("clr_sticky", {sticky_ovf, sticky_carry}, 2'b00);
    check("clr_data_kept", u_if.out_result, 32'h1234);
    step();

    // carry on ADD sets sticky_carry; carry on NOR does not count
    drive(1'b1, 32'h0, 1'b1, 1'b0, CMD_NOR);
    step();
    check("nor_carry", sticky_carry, 1'b0);
    check("nor_zero_flag", u_if.out_zero, 1'b1);
    drive(1'b1, 32'h9, 1'b1, 1'b1, CMD_ADD);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    check("add_count", ovf_count, 16'd1);
    check("add_sticky", {sticky_ovf, sticky_carry}, {STICKY, STICKY});
    check("add_out_flags", {u_if.out_carryout, u_if.out_overflow}, 2'b11);
    step();

    // reset while FULL
    u_if.out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, CMD_AND);
    step();
    drive(1'b1, 32'h22, 1'b0, 1'b0, CMD_AND);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    check("pre_rst_full", u_if.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", u_if.out_valid, 1'b0);
    check("mid_rst_ready", u_if.in_ready, 1'b1);
    check("mid_rst_count", ovf_count, 16'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", u_if.out_valid, 1'b0);
    u_if.out_ready = 1'b1;
    drive(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, CMD_OR);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, CMD_ADD);
    check("post_rst_result", {u_if.out_valid, u_if.out_result}, {1'b1, 32'hA5A5_A5A5});
    step();
    check("post_rst_alone", u_if.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
